demod_mode_scheduler: RTL and testbench
=======================================

// Module: demod_mode_scheduler
// PURPOSE
//  Automatic mode controller for the AM/ASK, BPSK and FM demodulation datapath. It drives the
//  datapath's 2-bit mode select. For each mode it selects that mode, lets the chain settle, then
//  measures the activity of the selected output over a fixed window, and locks the mode with the
//  highest activity. While locked it re-scans periodically with hysteresis; a manual override bypasses it.
// PARAMETERS
//  WIN_LEN     4096     samples (sample_vld pulses) per measurement window, >=2
//  SETTLE_CYC  64       clk cycles ignored after every mode_select change, >=1
//  RESCAN_PER  1048576  clk cycles spent in HOLD before the next background scan
//  MIN_ACT     1024     minimum window activity for a mode to be considered present
//  HYST_SHIFT  3        challenger must beat incumbent by incumbent>>HYST_SHIFT (12.5%)
// PORTS
//  clk          in   1   datapath clock (100 MHz domain)
//  rst_n        in   1   synchronous reset, active low
//  en           in   1   1 = run auto scheduling; 0 = park in IDLE
//  force_vld    in   1   1 = manual override active
//  force_mode   in   2   mode used while force_vld=1
//  sample_vld   in   1   qualifies sample_in (one demod output sample)
//  sample_in    in   16  signed demod output, already sign/zero-extended by the integrator
//  mode_select  out  2   00 AM, 01 BPSK, 10 FM, 11 none (datapath outputs zero)
//  out_valid    out  1   demod output is usable (locked or forced); low while scanning
//  scan_busy    out  1   scan in progress
//  locked       out  1   a mode has been chosen by auto scan
//  best_act     out  32  activity of the locked mode (0 when not locked)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, mode_select=11, out_valid=0, scan_busy=0, locked=0,
//   best_act=0, all counters and accumulators cleared. A mid-scan reset aborts the scan immediately.
//  Activity: act += |sample_in - prev| per sample_vld, using a 17-bit difference and an absolute
//   value. The accumulator is 32-bit unsigned and saturates at 32'hFFFF_FFFF. prev is cleared on entry
//   to MEASURE, and the first sample of a window only loads prev (it contributes no difference).
//  FSM (registered outputs, each output changes 1 cycle after its state transition):
//   IDLE    : mode_select=11. en=1 -> SWITCH with scan_idx=AM and cand cleared.
//   SWITCH  : mode_select=scan_idx, scan_busy=1, settle counter runs SETTLE_CYC cycles -> MEASURE.
//   MEASURE : accumulate the window. WIN_LEN-th sample_vld -> COMPARE (1 cycle).
//   COMPARE : act>cand_act -> cand=(scan_idx,act); a strict compare means a tie keeps the lower mode code.
//             If scan_idx<FM -> SWITCH with scan_idx+1. Otherwise -> DECIDE.
//   DECIDE  : (1 cycle)
//             cand_act<MIN_ACT -> mode_select=11, locked=0, best_act=0, -> HOLD.
//             First scan, or not locked -> lock cand.
//             Locked and cand=incumbent -> relock and update best_act.
//             Locked and cand differs -> switch only if cand_act > best+(best>>HYST_SHIFT);
//             otherwise restore the incumbent and refresh its best_act from this scan.
//   HOLD    : mode_select=locked mode (or 11), scan_busy=0, out_valid=locked.
//             The rescan timer reaching RESCAN_PER -> SWITCH with scan_idx=AM.
//   FORCED  : entered from any state when force_vld=1 (highest priority). mode_select=force_mode,
//             out_valid=1, locked=0, scan_busy=0. force_vld=0 -> IDLE.
//  en=0 in any non-FORCED state -> IDLE at the next edge; partial scan results are discarded.
//  While scanning out_valid=0, even if a previous lock exists; mode_select reflects the scanned mode.
//  sample_vld outside MEASURE is ignored, as is sample_vld during the cycle that leaves MEASURE.
//  The rescan timer is 21-bit; the settle and window counters are sized by $clog2 of their parameter.
//   All counters clear on state entry.
//  Latency: a full scan takes 3*(SETTLE_CYC + WIN_LEN sample periods + 1) + 1 cycles.
// STRUCTURE
//  demod_pkg: typedef enum logic[1:0] mode_t {MODE_AM=2'b00, MODE_BPSK=2'b01, MODE_FM=2'b10,
//   MODE_NONE=2'b11}; typedef enum sched_state_t {IDLE,SWITCH,MEASURE,COMPARE,DECIDE,HOLD,FORCED};
//   ACT_W=32. The integration top also imports mode_t for its select case.
//  Sub-module demod_act_meter (clk, rst_n, clr, sample_vld, sample_in -> act[31:0]) holds the
//   difference/abs/saturating accumulator. The FSM, counters and decision logic stay in this module.
// TESTING
//  Reset mid-MEASURE (WIN_LEN=16, SETTLE_CYC=4) -> next cycle mode_select=11, scan_busy=0, best_act=0.
//  Square waves of amplitude 10/200/40 fed in the AM/BPSK/FM windows, WIN_LEN=16 -> lock
//   mode_select=01, best_act=15*400=6000, out_valid=1 after DECIDE.
//  Identical activity 6000 in all three windows -> mode_select=00 (tie keeps the lowest code).
//  Locked BPSK at 6000; rescan gives FM 6700 (<6750) -> stays 01. FM 6800 -> switches to 10, best_act=6800.
//  Constant sample_in in every window -> mode_select=11, locked=0, out_valid=0, rescan after RESCAN_PER.
//  force_vld=1, force_mode=10 during SWITCH -> mode_select=10, out_valid=1 next cycle.
//   force_vld=0 -> IDLE, then a fresh scan from AM.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared types for the demodulator mode scheduler.
// Mode codes match the datapath select encoding.
package demod_pkg;

  localparam int ACT_W = 32;

  typedef enum logic [1:0] {
    MODE_AM   = 2'b00,
    MODE_BPSK = 2'b01,
    MODE_FM   = 2'b10,
    MODE_NONE = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    MEASURE,
    COMPARE,
    DECIDE,
    HOLD,
    FORCED
  } sched_state_t;

endpackage

// File: rtl/demod_act_meter.sv
// Activity meter: saturating sum of |x[n]-x[n-1]|.
// The first sample after clr only seeds the history.
module demod_act_meter
  import demod_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample_vld,
  input  logic [15:0]      sample_in,
  output logic [ACT_W-1:0] act
);

  logic [15:0]      r_prev;
  logic             r_have;
  logic [ACT_W-1:0] r_act;
  logic [16:0]      w_diff;
  logic [16:0]      w_abs;
  logic [ACT_W:0]   w_sum;

  assign w_diff = {sample_in[15], sample_in} - {r_prev[15], r_prev};
  assign w_abs  = w_diff[16] ? (17'd0 - w_diff) : w_diff;
  assign w_sum  = {1'b0, r_act} + {{(ACT_W - 16){1'b0}}, w_abs};
  assign act    = r_act;

  // history register and saturating accumulator
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_prev <= '0;
      r_have <= 1'b0;
      r_act  <= '0;
    end else if (sample_vld) begin
      r_prev <= sample_in;
      r_have <= 1'b1;
      if (r_have)
        r_act <= w_sum[ACT_W] ? '1 : w_sum[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/demod_mode_scheduler.sv
// Auto mode scan: settle, measure, compare, lock with hysteresis.
// Outputs are registered from the next state.
module demod_mode_scheduler
  import demod_pkg::*;
#(
  parameter int WIN_LEN    = 4096,
  parameter int SETTLE_CYC = 64,
  parameter int RESCAN_PER = 1048576,
  parameter int MIN_ACT    = 1024,
  parameter int HYST_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        force_vld,
  input  logic [1:0]  force_mode,
  input  logic        sample_vld,
  input  logic [15:0] sample_in,
  output logic [1:0]  mode_select,
  output logic        out_valid,
  output logic        scan_busy,
  output logic        locked,
  output logic [31:0] best_act
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int WW = $clog2(WIN_LEN);
  localparam int RW = 21;

  sched_state_t     r_state, w_nxt;
  mode_t            r_idx, w_idx;
  mode_t            r_cmode, w_cmode;
  mode_t            r_lmode, w_lmode;
  logic [ACT_W-1:0] r_cact, w_cact;
  logic [ACT_W-1:0] r_inc, w_inc;
  logic [ACT_W-1:0] r_best, w_best;
  logic             r_locked, w_locked;
  logic [1:0]       r_msel, w_msel;
  logic             r_ovld, w_ovld;
  logic             r_busy, w_busy;
  logic [SW-1:0]    r_set;
  logic [WW-1:0]    r_win;
  logic [RW-1:0]    r_tmr;
  logic [ACT_W-1:0] w_act;
  logic [ACT_W:0]   w_hyst;
  logic             w_mvld;
  logic             w_clr;

  assign w_mvld = sample_vld && en && !force_vld && (r_state == MEASURE);
  assign w_clr  = (r_state != MEASURE);
  assign w_hyst = {1'b0, r_best} + {1'b0, (r_best >> HYST_SHIFT)};

  demod_act_meter u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .sample_vld(w_mvld),
    .sample_in (sample_in),
    .act       (w_act)
  );

  // next state, scan bookkeeping and next output values
  always_comb begin
    w_nxt    = r_state;
    w_idx    = r_idx;
    w_cmode  = r_cmode;
    w_cact   = r_cact;
    w_inc    = r_inc;
    w_lmode  = r_lmode;
    w_best   = r_best;
    w_locked = r_locked;
    w_msel   = MODE_NONE;
    w_ovld   = 1'b0;
    w_busy   = 1'b0;
    if (force_vld) begin
      w_nxt    = FORCED;
      w_locked = 1'b0;
      w_best   = '0;
    end else if (r_state == FORCED || !en) begin
      w_nxt    = IDLE;
      w_locked = 1'b0;
      w_best   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_nxt   = SWITCH;
          w_idx   = MODE_AM;
          w_cmode = MODE_AM;
          w_cact  = '0;
        end
        SWITCH:
          if (r_set == SW'(SETTLE_CYC - 1))
            w_nxt = MEASURE;
        MEASURE:
          if (sample_vld && r_win == WW'(WIN_LEN - 1))
            w_nxt = COMPARE;
        COMPARE: begin
          if (w_act > r_cact) begin
            w_cmode = r_idx;
            w_cact  = w_act;
          end
          if (r_idx == r_lmode)
            w_inc = w_act;
          if (r_idx != MODE_FM) begin
            w_idx = mode_t'(r_idx + 2'd1);
            w_nxt = SWITCH;
          end else begin
            w_nxt = DECIDE;
          end
        end
        DECIDE: begin
          w_nxt = HOLD;
          if (r_cact < ACT_W'(MIN_ACT)) begin
            w_locked = 1'b0;
            w_lmode  = MODE_NONE;
            w_best   = '0;
          end else if (!r_locked || r_cmode == r_lmode ||
                       {1'b0, r_cact} > w_hyst) begin
            w_locked = 1'b1;
            w_lmode  = r_cmode;
            w_best   = r_cact;
          end else begin
            w_best = r_inc;
          end
        end
        HOLD:
          if (r_tmr == RW'(RESCAN_PER - 1)) begin
            w_nxt   = SWITCH;
            w_idx   = MODE_AM;
            w_cmode = MODE_AM;
            w_cact  = '0;
          end
        default: w_nxt = IDLE;
      endcase
    end
    unique case (w_nxt)
      SWITCH, MEASURE, COMPARE, DECIDE: begin
        w_msel = w_idx;
        w_busy = 1'b1;
      end
      HOLD: begin
        w_msel = w_locked ? w_lmode : MODE_NONE;
        w_ovld = w_locked;
      end
      FORCED: begin
        w_msel = force_mode;
        w_ovld = 1'b1;
      end
      default: ;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_msel  <= MODE_NONE;
      r_ovld  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_msel  <= w_msel;
      r_ovld  <= w_ovld;
      r_busy  <= w_busy;
    end
  end

  // scan results, lock and counters cleared on state entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= MODE_AM;
      r_cmode  <= MODE_AM;
      r_cact   <= '0;
      r_inc    <= '0;
      r_lmode  <= MODE_NONE;
      r_best   <= '0;
      r_locked <= 1'b0;
      r_set    <= '0;
      r_win    <= '0;
      r_tmr    <= '0;
    end else begin
      r_idx    <= w_idx;
      r_cmode  <= w_cmode;
      r_cact   <= w_cact;
      r_inc    <= w_inc;
      r_lmode  <= w_lmode;
      r_best   <= w_best;
      r_locked <= w_locked;
      if (w_nxt != r_state) begin
        r_set <= '0;
        r_win <= '0;
        r_tmr <= '0;
      end else begin
        if (r_state == SWITCH) r_set <= r_set + 1'b1;
        if (w_mvld)            r_win <= r_win + 1'b1;
        if (r_state == HOLD)   r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign mode_select = r_msel;
  assign out_valid   = r_ovld;
  assign scan_busy   = r_busy;
  assign locked      = r_locked;
  assign best_act    = r_best;

endmodule

// File: tb/tb_demod_mode_scheduler.sv
// Scoreboard bench for demod_mode_scheduler.
// Square-wave generator follows mode_select; monitor checks scan edges.
module tb_demod_mode_scheduler;

  localparam int WIN  = 16;
  localparam int SET  = 4;
  localparam int RESC = 200;
  localparam int SCAN = 3 * (SET + WIN + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        force_vld;
  logic [1:0]  force_mode;
  logic        sample_vld;
  logic [15:0] sample_in;
  logic [1:0]  mode_select;
  logic        out_valid;
  logic        scan_busy;
  logic        locked;
  logic [31:0] best_act;

  demod_mode_scheduler #(
    .WIN_LEN   (WIN),
    .SETTLE_CYC(SET),
    .RESCAN_PER(RESC),
    .MIN_ACT   (1024),
    .HYST_SHIFT(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .force_vld  (force_vld),
    .force_mode (force_mode),
    .sample_vld (sample_vld),
    .sample_in  (sample_in),
    .mode_select(mode_select),
    .out_valid  (out_valid),
    .scan_busy  (scan_busy),
    .locked     (locked),
    .best_act   (best_act)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        ov;
    logic        lk;
    logic [31:0] best;
    int          dur;
  } end_t;

  typedef struct {
    logic [1:0] mode;
    int         gap;
  } start_t;

  end_t   q_end[$];
  start_t q_start[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     amp[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic set_amp(input int a0, input int a1, input int a2);
    amp[0] = a0;
    amp[1] = a1;
    amp[2] = a2;
  endtask

  task automatic push(input int gap, input logic [1:0] m,
                      input logic ov, input logic lk,
                      input logic [31:0] b, input int dur);
    start_t s;
    end_t   e;
    s.mode = 2'b00;
    s.gap  = gap;
    e.mode = m;
    e.ov   = ov;
    e.lk   = lk;
    e.best = b;
    e.dur  = dur;
    q_start.push_back(s);
    q_end.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((q_start.size() != 0 || q_end.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (q_start.size() != 0 || q_end.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d events still pending after %0d cycles",
               q_start.size() + q_end.size(), maxc);
      q_start.delete();
      q_end.delete();
    end
  endtask

  task automatic wait_busy(input int maxc);
    int n = 0;
    while (!scan_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!scan_busy) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: scan_busy 0 after %0d cycles, need 1", maxc);
    end
  endtask

  // square wave around 1000, amplitude chosen by the selected mode
  initial begin
    logic tog;
    int   a;
    tog        = 1'b0;
    sample_vld = 1'b1;
    sample_in  = 16'd1000;
    forever begin
      @(negedge clk);
      tog = !tog;
      a   = (mode_select < 2'd3) ? amp[mode_select] : 0;
      sample_in = 16'(tog ? 1000 + a : 1000 - a);
    end
  end

  // monitor: scan start and scan end are the observed outputs
  initial begin
    logic   pb;
    int     t_rise;
    int     t_fall;
    start_t s;
    end_t   e;
    pb     = 1'b0;
    t_rise = 0;
    t_fall = 0;
    forever begin
      @(negedge clk);
      if (scan_busy === 1'b1 && !pb) begin
        t_rise = cyc;
        if (q_start.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start: unexpected scan start, mode %0d", mode_select);
        end else begin
          s = q_start.pop_front();
          chk("start", {mode_select, out_valid}, {s.mode, 1'b0});
          if (s.gap != 0)
            chk("rescan_gap", t_rise - t_fall, s.gap);
        end
      end
      if (scan_busy === 1'b0 && pb) begin
        t_fall = cyc;
        if (q_end.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL end: unexpected scan end, mode %0d", mode_select);
        end else begin
          e = q_end.pop_front();
          chk("result", {mode_select, out_valid, locked, best_act},
              {e.mode, e.ov, e.lk, e.best});
          if (e.dur != 0)
            chk("latency", t_fall - t_rise, e.dur);
        end
      end
      pb = (scan_busy === 1'b1);
    end
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    force_vld  = 1'b0;
    force_mode = 2'b00;
    set_amp(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_mode", mode_select, 2'b11);
    chk("rst_flags", {out_valid, scan_busy, locked}, 3'b000);
    chk("rst_best", best_act, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_amp(10, 200, 40);
    push(0, 2'b01, 1'b1, 1'b1, 32'd6000, SCAN);
    en = 1'b1;
    drain(400);

    set_amp(0, 200, 223);
    push(RESC, 2'b01, 1'b1, 1'b1, 32'd6000, SCAN);
    drain(600);

    set_amp(0, 200, 225);
    push(RESC, 2'b01, 1'b1, 1'b1, 32'd6000, SCAN);
    drain(600);

    set_amp(0, 200, 226);
    push(RESC, 2'b10, 1'b1, 1'b1, 32'd6780, SCAN);
    drain(600);

    set_amp(200, 200, 200);
    push(RESC, 2'b10, 1'b1, 1'b1, 32'd6000, SCAN);
    drain(600);

    en = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 2'b00, 1'b1, 1'b1, 32'd6000, SCAN);
    en = 1'b1;
    drain(400);

    set_amp(0, 0, 0);
    push(RESC, 2'b11, 1'b0, 1'b0, 32'd0, SCAN);
    drain(600);

    set_amp(0, 34, 0);
    push(RESC, 2'b11, 1'b0, 1'b0, 32'd0, SCAN);
    drain(600);

    set_amp(10, 200, 40);
    push(RESC, 2'b10, 1'b1, 1'b0, 32'd0, 0);
    wait_busy(400);
    force_vld  = 1'b1;
    force_mode = 2'b10;
    drain(10);
    repeat (4) @(negedge clk);
    push(0, 2'b01, 1'b1, 1'b1, 32'd6000, SCAN);
    force_vld = 1'b0;
    drain(400);

    en = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 2'b11, 1'b0, 1'b0, 32'd0, 0);
    en = 1'b1;
    wait_busy(20);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    drain(10);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("pending", q_start.size() + q_end.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
